perf_event_counters: RTL and testbench
======================================

// Module: perf_event_counters
// PURPOSE
//  Parametrised bank of performance-event counters plus a run-control watchdog for mp4 benches/debug.
//  Counts NUM_EVENTS event strobes (hits, misses, mispredicts, stalls, ...) and core cycles.
//  Stops counting on halt or on commit starvation (timeout).
//  Snapshots counters for indexed readout. Sits beside the DUT; taps dut-internal strobes and monitor valid.
// PARAMETERS
//  NUM_EVENTS      8       number of event channels (>=1)
//  COUNT_WIDTH     32      width of every counter, incl. cycle counter
//  EDGE_MASK       '0      NUM_EVENTS bits; bit i=1 -> channel i counts rising edges only, 0 -> counts every high cycle
//  TIMEOUT_CYCLES  10000   consecutive RUN cycles without commit before TIMEOUT; 0 disables watchdog
//  SEL_W           $clog2(NUM_EVENTS) (min 1)   width of rd_sel_i
// PORTS
//  clk            in   1            clock
//  rst            in   1            reset, asynchronous, active-high
//  enable_i       in   1            start / run-gate; low in RUN = pause
//  clear_i        in   1            synchronous clear of counters, sticky bits, watchdog; FSM -> IDLE
//  event_i        in   NUM_EVENTS   event strobes
//  commit_i       in   1            instruction retired (monitor valid); kicks watchdog
//  halt_i         in   1            program halted
//  snap_i         in   1            capture all counters into snapshot regs
//  rd_sel_i       in   SEL_W        snapshot channel select
//  rd_count_o     out  COUNT_WIDTH  registered snapshot[rd_sel_i]
//  cycle_count_o  out  COUNT_WIDTH  live cycle counter
//  overflow_o     out  NUM_EVENTS   sticky per-channel overflow
//  state_o        out  2            00 IDLE, 01 RUN, 10 HALTED, 11 TIMEOUT
//  timeout_o      out  1            high while state==TIMEOUT
// BEHAVIOUR
//  Reset: all outputs, counters, snapshots, watchdog, event-history regs = 0; state IDLE.
//  FSM: IDLE -enable_i-> RUN.
//   RUN -halt_i-> HALTED.
//   RUN -(wdog==TIMEOUT_CYCLES-1 && !commit_i && enable_i)-> TIMEOUT.
//   HALTED/TIMEOUT are terminal until clear_i.
//  Priority: clear_i > halt_i > timeout. Halt and timeout in the same cycle -> HALTED.
//  Counting: only in RUN with enable_i=1, including the cycle halt/timeout is detected.
//   cycle_count_o +1 per such cycle. Channel i +1 if event_i[i] (level) or event_i[i]&~prev[i] (edge).
//   prev[i] is updated every cycle in all states. prev=0 after reset: an event already high counts once.
//  Watchdog: counts qualifying RUN cycles. Cleared on commit_i, or in any non-RUN state. Held when enable_i=0.
//  Wrap: counter at all-ones + increment -> 0; overflow_o[i] set. Cycle counter wraps silently.
//  Snapshot: snap_i at edge t stores the register values present during cycle t (pre-increment). Allowed in any state.
//  Readout: rd_count_o(t+1) = snap[rd_sel_i(t)]. rd_sel_i >= NUM_EVENTS -> 0. snap+read same cycle returns the old snapshot.
//  clear_i: zeros counters, overflow, watchdog, snapshots, rd_count_o next edge. Mid-RUN clear drops that cycle's increments.
//  Async rst mid-operation: immediate return to reset values; no partial counts retained.
// CONFIGURATION
//  PERF_SATURATE_EN defined: event counters saturate at all-ones. overflow_o[i] set on the first blocked increment. Cycle counter also saturates.
//  Undefined: wrap-around as above.
// TESTING
//  rst 2 cycles, enable_i=1, event_i[0] level high 5 cycles, 3 commits -> snap, rd_sel=0 -> rd_count_o=5, state_o=01.
//  EDGE_MASK[1]=1, event_i[1] high 4 cycles, low 1, high 2 -> channel 1 = 2; same pattern on level ch2 -> 6.
//  TIMEOUT_CYCLES=16, no commit_i after entering RUN -> state_o=11, timeout_o=1 on edge 16; cycle_count_o=16, frozen after.
//  halt_i and watchdog expiry in same cycle -> state_o=10; further events not counted; clear_i -> IDLE, all counts 0.
//  COUNT_WIDTH=4, 17 level events on ch0 -> wrap build: count 1, overflow_o[0]=1; PERF_SATURATE_EN build: count 15, overflow_o[0]=1.
//  rst asserted mid-RUN with counts nonzero -> same-cycle outputs 0, state IDLE; rd_sel_i=NUM_EVENTS -> rd_count_o=0.

Source files
------------

// File: rtl/perf_event_counters.sv
// Performance-event counter bank with run-control watchdog and snapshot readout.
// Define PERF_SATURATE_EN to make counters saturate instead of wrapping.
module perf_event_counters #(
  parameter int NUM_EVENTS = 8,
  parameter int COUNT_WIDTH = 32,
  parameter logic [NUM_EVENTS-1:0] EDGE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int SEL_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic [NUM_EVENTS-1:0]  event_i,
  input  logic                   commit_i,
  input  logic                   halt_i,
  input  logic                   snap_i,
  input  logic [SEL_W-1:0]       rd_sel_i,
  output logic [COUNT_WIDTH-1:0] rd_count_o,
  output logic [COUNT_WIDTH-1:0] cycle_count_o,
  output logic [NUM_EVENTS-1:0]  overflow_o,
  output logic [1:0]             state_o,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_HALTED  = 2'b10,
    S_TIMEOUT = 2'b11
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] ONES = '1;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] cnt  [NUM_EVENTS];
  logic [COUNT_WIDTH-1:0] snap [NUM_EVENTS];
  logic [31:0]            wdog;
  logic [NUM_EVENTS-1:0]  prev;
  logic [NUM_EVENTS-1:0]  inc;
  logic [COUNT_WIDTH-1:0] rd_next;
  logic                   count_en;
  logic                   expire;

  assign count_en = (state == S_RUN) && enable_i;
  // edge channels mask out cycles where the strobe was already high
  assign inc = count_en ? (event_i & ~(prev & EDGE_MASK)) : '0;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_wdog
      assign expire = 1'b0;
    end else begin : g_wdog
      assign expire = count_en && !commit_i &&
                      (wdog == 32'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (rd_sel_i == SEL_W'(i)) rd_next = snap[i];
    end
  end

  assign state_o   = state;
  assign timeout_o = (state == S_TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      wdog          <= '0;
      prev          <= '0;
      overflow_o    <= '0;
      cycle_count_o <= '0;
      rd_count_o    <= '0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
    end else begin
      prev <= event_i;
      if (clear_i) begin
        state         <= S_IDLE;
        wdog          <= '0;
        overflow_o    <= '0;
        cycle_count_o <= '0;
        rd_count_o    <= '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
          cnt[i]  <= '0;
          snap[i] <= '0;
        end
      end else begin
        unique case (state)
          S_IDLE:    if (enable_i) state <= S_RUN;
          S_RUN: begin
            if (halt_i)      state <= S_HALTED;
            else if (expire) state <= S_TIMEOUT;
          end
          S_HALTED:  ;
          S_TIMEOUT: ;
        endcase

        if (state != S_RUN || commit_i) wdog <= '0;
        else if (enable_i)              wdog <= wdog + 32'd1;

        rd_count_o <= rd_next;
        if (snap_i) begin
          for (int i = 0; i < NUM_EVENTS; i++) snap[i] <= cnt[i];
        end

        if (count_en) begin
`ifdef PERF_SATURATE_EN
          if (cycle_count_o != ONES)
            cycle_count_o <= cycle_count_o + COUNT_WIDTH'(1);
`else
          cycle_count_o <= cycle_count_o + COUNT_WIDTH'(1);
`endif
        end

        for (int i = 0; i < NUM_EVENTS; i++) begin
          if (inc[i]) begin
`ifdef PERF_SATURATE_EN
            if (cnt[i] == ONES) overflow_o[i] <= 1'b1;
            else                cnt[i] <= cnt[i] + COUNT_WIDTH'(1);
`else
            cnt[i] <= cnt[i] + COUNT_WIDTH'(1);
            if (cnt[i] == ONES) overflow_o[i] <= 1'b1;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_perf_event_counters.sv
// Randomised + directed bench for perf_event_counters against a behavioural model.
// Honours PERF_SATURATE_EN in the reference model.
module tb_perf_event_counters;

  localparam int NE   = 5;
  localparam int CW   = 4;
  localparam int TO   = 16;
  localparam int MAXV = (1 << CW) - 1;
  localparam logic [NE-1:0] EM = 5'b00010;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable_i, clear_i, commit_i, halt_i, snap_i;
  logic [NE-1:0] event_i;
  logic [2:0]    rd_sel_i;
  logic [CW-1:0] rd_count_o, cycle_count_o;
  logic [NE-1:0] overflow_o;
  logic [1:0]    state_o;
  logic          timeout_o;

  perf_event_counters #(
    .NUM_EVENTS(NE), .COUNT_WIDTH(CW),
    .EDGE_MASK(EM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .enable_i(enable_i), .clear_i(clear_i),
    .event_i(event_i), .commit_i(commit_i),
    .halt_i(halt_i), .snap_i(snap_i),
    .rd_sel_i(rd_sel_i), .rd_count_o(rd_count_o),
    .cycle_count_o(cycle_count_o),
    .overflow_o(overflow_o), .state_o(state_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: plain integers, state as a number 0..3
  int          m_cnt  [NE];
  int          m_snap [NE];
  logic [NE-1:0] m_ovf;
  logic [NE-1:0] m_prev;
  int          m_cyc, m_state, m_wd, m_rd;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_cnt[i]  = 0;
      m_snap[i] = 0;
    end
    m_ovf = '0; m_prev = '0;
    m_cyc = 0; m_state = 0; m_wd = 0; m_rd = 0;
  endtask

  task automatic model_step();
    int  nxt_rd;
    bit  run;
    bit  hit;
    nxt_rd = (int'(rd_sel_i) < NE) ? m_snap[rd_sel_i] : 0;
    run    = (m_state == 1) && enable_i;
    if (clear_i) begin
      for (int i = 0; i < NE; i++) begin
        m_cnt[i]  = 0;
        m_snap[i] = 0;
      end
      m_ovf = '0; m_cyc = 0; m_state = 0; m_wd = 0; m_rd = 0;
    end else begin
      m_rd = nxt_rd;
      if (snap_i) m_snap = m_cnt;
      if (run) begin
        m_cyc = m_cyc + 1;
        if (m_cyc > MAXV) begin
`ifdef PERF_SATURATE_EN
          m_cyc = MAXV;
`else
          m_cyc = 0;
`endif
        end
        for (int i = 0; i < NE; i++) begin
          hit = event_i[i] && !(EM[i] && m_prev[i]);
          if (hit) begin
            if (m_cnt[i] == MAXV) begin
              m_ovf[i] = 1'b1;
`ifndef PERF_SATURATE_EN
              m_cnt[i] = 0;
`endif
            end else begin
              m_cnt[i] = m_cnt[i] + 1;
            end
          end
        end
      end
      if (m_state == 0) begin
        if (enable_i) m_state = 1;
        m_wd = 0;
      end else if (m_state == 1) begin
        if (halt_i) m_state = 2;
        else if (run && !commit_i && m_wd == TO - 1) m_state = 3;
        if (commit_i) m_wd = 0;
        else if (enable_i) m_wd = m_wd + 1;
      end else begin
        m_wd = 0;
      end
    end
    m_prev = event_i;
  endtask

  task automatic compare_all();
    check("state", int'(state_o), m_state);
    check("timeout", int'(timeout_o), int'(m_state == 3));
    check("cycles", int'(cycle_count_o), m_cyc);
    check("overflow", int'(overflow_o), int'(m_ovf));
    check("rd_count", int'(rd_count_o), m_rd);
  endtask

  task automatic go(input logic en, input logic cl, input logic cm,
                    input logic ht, input logic sn,
                    input logic [NE-1:0] ev, input logic [2:0] sel);
    enable_i = en; clear_i = cl; commit_i = cm;
    halt_i = ht; snap_i = sn; event_i = ev; rd_sel_i = sel;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1;
    enable_i = 0; clear_i = 0; commit_i = 0; halt_i = 0; snap_i = 0;
    event_i = '0; rd_sel_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", int'(state_o), 0);
    check("rst_cycles", int'(cycle_count_o), 0);
    check("rst_ovf", int'(overflow_o), 0);
    check("rst_rd", int'(rd_count_o), 0);
    rst = 1'b0;

    // level channel 0: five high cycles, three commits
    go(1, 0, 0, 0, 0, '0, 0);
    for (int k = 0; k < 5; k++) go(1, 0, k < 3, 0, 0, 5'b00001, 0);
    go(1, 0, 0, 0, 1, '0, 0);
    go(1, 0, 0, 0, 0, '0, 0);
    check("lvl_rd", int'(rd_count_o), 5);
    check("lvl_state", int'(state_o), 1);

    // edge ch1 vs level ch2 with pattern 4 high, 1 low, 2 high
    go(0, 1, 0, 0, 0, '0, 0);
    go(1, 0, 1, 0, 0, '0, 0);
    for (int k = 0; k < 4; k++) go(1, 0, 1, 0, 0, 5'b00110, 0);
    go(1, 0, 1, 0, 0, '0, 0);
    for (int k = 0; k < 2; k++) go(1, 0, 1, 0, 0, 5'b00110, 0);
    go(1, 0, 1, 0, 1, '0, 1);
    go(1, 0, 1, 0, 0, '0, 1);
    check("edge_rd", int'(rd_count_o), 2);
    go(1, 0, 1, 0, 0, '0, 2);
    check("level_rd", int'(rd_count_o), 6);

    // watchdog expiry with no commits
    go(0, 1, 0, 0, 0, '0, 0);
    go(1, 0, 0, 0, 0, '0, 0);
    for (int k = 0; k < 15; k++) go(1, 0, 0, 0, 0, '0, 0);
    check("pre_to_state", int'(state_o), 1);
    go(1, 0, 0, 0, 0, '0, 0);
    check("to_state", int'(state_o), 3);
    check("to_flag", int'(timeout_o), 1);
    check("to_cycles", int'(cycle_count_o), 16 % (MAXV + 1));
    for (int k = 0; k < 3; k++) go(1, 0, 1, 0, 0, 5'b11111, 0);
    check("to_frozen", int'(cycle_count_o), 16 % (MAXV + 1));

    // halt coincident with expiry: halt wins
    go(0, 1, 0, 0, 0, '0, 0);
    go(1, 0, 0, 0, 0, '0, 0);
    for (int k = 0; k < 15; k++) go(1, 0, 0, 0, 0, 5'b00001, 0);
    go(1, 0, 0, 1, 0, 5'b00001, 0);
    check("halt_state", int'(state_o), 2);
    for (int k = 0; k < 3; k++) go(1, 0, 0, 0, 0, 5'b11111, 0);
    go(1, 0, 0, 0, 1, '0, 0);
    go(1, 0, 0, 0, 0, '0, 0);
    check("halt_frozen", int'(rd_count_o), 0);
    go(0, 1, 0, 0, 0, '0, 0);
    check("clr_state", int'(state_o), 0);
    check("clr_cycles", int'(cycle_count_o), 0);

    // 17 level events on a 4-bit counter
    go(1, 0, 0, 0, 0, '0, 0);
    for (int k = 0; k < 17; k++) go(1, 0, 1, 0, 0, 5'b00001, 0);
    go(1, 0, 1, 0, 1, '0, 0);
    go(1, 0, 1, 0, 0, '0, 0);
`ifdef PERF_SATURATE_EN
    check("wrap_rd", int'(rd_count_o), 15);
`else
    check("wrap_rd", int'(rd_count_o), 1);
`endif
    check("wrap_ovf0", int'(overflow_o[0]), 1);

    // randomised traffic
    go(0, 1, 0, 0, 0, '0, 0);
    for (int k = 0; k < 600; k++) begin
      go($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
         $urandom_range(0, 9) < 2, $urandom_range(0, 59) == 0,
         $urandom_range(0, 7) == 0, NE'($urandom),
         3'($urandom_range(0, 7)));
    end

    // async reset mid-run
    go(0, 1, 0, 0, 0, '0, 0);
    go(1, 0, 1, 0, 0, '0, 0);
    for (int k = 0; k < 6; k++) go(1, 0, 1, 0, 0, 5'b11111, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_state", int'(state_o), 0);
    check("arst_cycles", int'(cycle_count_o), 0);
    check("arst_ovf", int'(overflow_o), 0);
    check("arst_timeout", int'(timeout_o), 0);
    check("arst_rd", int'(rd_count_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    go(1, 0, 1, 0, 0, '0, 0);
    for (int k = 0; k < 3; k++) go(1, 0, 1, 0, 0, 5'b11111, 0);
    go(1, 0, 1, 0, 1, '0, 0);
    go(1, 0, 1, 0, 0, '0, 3'(NE));
    check("sel_oob", int'(rd_count_o), 0);
    go(1, 0, 1, 0, 0, '0, 0);
    check("sel0_after", int'(rd_count_o), 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
